br_pred_update_ctrl: RTL and testbench
======================================

Name: br_pred_update_ctrl

Overview:
Update scheduler for the tournament branch predictor (global, local and meta tables). It tracks every in-flight predicted branch from fetch to resolution in MEM, and owns the speculative global history register (GHR). At resolution it sequences one update pulse to the predictor tables and raises the pipeline flush on a mispredict. It also repairs the GHR and keeps branch/mispredict performance counters.

Parameters:
DEPTH, 4, in-flight branch queue entries (power of 2, >=2)
GHR_W, 8, global history width
CNT_W, 32, performance counter width

Ports:
clk  in  1  clock
rst  in  1  reset
stall  in  1  pipeline stall; freezes queue, GHR, counters
pred_valid  in  1  fetch predicted a branch this cycle
pred_pc  in  32  PC of predicted branch
pred_taken  in  1  final (selected) prediction
pred_global  in  1  global predictor's direction
pred_local  in  1  local predictor's direction
pred_ready  out  1  queue can accept (count != DEPTH)
res_valid  in  1  branch resolved in MEM stage
res_pc  in  32  PC of resolved branch
res_taken  in  1  actual direction
ghr  out  GHR_W  speculative global history to predictors
flush  out  1  mispredict flush pulse
upd_valid  out  1  table update strobe
upd_pc  out  32  PC for update
upd_taken  out  1  actual direction for update
upd_ghr  out  GHR_W  GHR snapshot used at prediction time
upd_meta_en  out  1  meta table update enable
upd_meta_sel  out  1  1 = local was correct, 0 = global was correct
err_unmatched  out  1  sticky: resolution did not match queue head
branch_cnt  out  CNT_W  resolved branches
mispred_cnt  out  CNT_W  mispredicted branches

Behaviour:
Clock/reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: queue empty, head/tail pointers 0, ghr=0, flush=0, upd_* all 0, err_unmatched=0, counters 0, pred_ready=1.
Enqueue:
- Accepted when pred_valid && pred_ready && !stall && no mispredict resolving this cycle.
- Entry stores {pred_pc, pred_taken, pred_global, pred_local, ghr (value before shift)}.
- Same edge: ghr <= {ghr[GHR_W-2:0], pred_taken}.
- pred_valid while !pred_ready is ignored; queue and GHR are unchanged.
Resolve:
- Considered only when res_valid && !stall.
- Unmatched: if the queue is empty or res_pc != head.pc, set err_unmatched (sticky until rst). No pop, no update, no flush, counters unchanged.
- Matched: pop head. Next cycle, upd_valid=1 for exactly one cycle, with:
  - upd_pc = head.pc
  - upd_taken = res_taken
  - upd_ghr = head.ghr
  - upd_meta_en = (head.pred_global != head.pred_local)
  - upd_meta_sel = (head.pred_local == res_taken)
- Matched resolve increments branch_cnt.
- Mispredict (res_taken != head.pred_taken):
  - flush=1 on the next cycle for one cycle, coincident with upd_valid.
  - Queue is cleared (all younger entries are wrong-path); count=0.
  - ghr <= {head.ghr[GHR_W-2:0], res_taken}.
  - mispred_cnt increments.
  - A same-cycle enqueue is dropped.
- Correct prediction: ghr is unchanged by the resolve. A same-cycle enqueue proceeds normally; count is unchanged when both happen.
Pointers and counters:
- Pointers wrap modulo DEPTH.
- pred_ready depends on count only; it does not consider a same-cycle pop.
- Counters saturate at all-ones; they do not wrap.
Stall and pulses:
- upd_valid and flush are registered pulses caused by an accepted resolve. A stall in the pulse cycle does not extend or suppress them.
- Latency: resolve accepted at edge N; update and flush are visible during cycle N+1.

Test Plan:
1. Reset, then enqueue 3 branches with PCs 0x100/0x200/0x300, all pred_taken=1 -> ghr=0x07, pred_ready=1. Resolve 0x100 taken -> upd_valid one cycle, upd_pc=0x100, upd_ghr=0x00, flush=0, branch_cnt=1.
2. Mispredict: entries 0x100 (ghr snap 0x00, pred 1) and 0x200 queued; resolve 0x100 not-taken -> flush=1 one cycle, queue empty, ghr=0x00, mispred_cnt=1. A later resolve of 0x200 sets err_unmatched=1.
3. Full: enqueue 4 branches -> pred_ready=0. A 5th pred_valid is ignored (ghr unchanged). Resolve one -> pred_ready=1.
4. Meta update: pred_global=0, pred_local=1, actual taken -> upd_meta_en=1, upd_meta_sel=1. With pred_global=pred_local=1 -> upd_meta_en=0.
5. Simultaneous push and pop on a correct prediction with count=2 -> count stays 2 and ghr shifts by the new prediction. Same cycle with a mispredict -> the enqueue is dropped and count=0.
6. Stall held high with pred_valid and res_valid asserted -> no state change. Assert rst mid-stream with 3 entries queued -> all outputs and counters return to their reset values on the next edge.

Source files
------------

// File: rtl/br_pred_update_ctrl.sv
// Tournament branch predictor update scheduler.
// Tracks in-flight branches, owns the speculative GHR, sequences table
// updates and mispredict flushes, and keeps branch/mispredict counters.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   stall               freezes queue, GHR and counters
//   pred_*              fetch-side prediction (valid/pc/taken/global/local)
//   pred_ready          queue not full
//   res_*               MEM-stage resolution (valid/pc/taken)
//   ghr                 speculative global history
//   flush               one-cycle mispredict flush
//   upd_*               one-cycle table update bundle
//   err_unmatched       sticky resolve/queue-head mismatch
//   branch_cnt          saturating count of resolved branches
//   mispred_cnt         saturating count of mispredicted branches
module br_pred_update_ctrl #(
    parameter int DEPTH = 4,
    parameter int GHR_W = 8,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             pred_valid,
    input  logic [31:0]      pred_pc,
    input  logic             pred_taken,
    input  logic             pred_global,
    input  logic             pred_local,
    output logic             pred_ready,
    input  logic             res_valid,
    input  logic [31:0]      res_pc,
    input  logic             res_taken,
    output logic [GHR_W-1:0] ghr,
    output logic             flush,
    output logic             upd_valid,
    output logic [31:0]      upd_pc,
    output logic             upd_taken,
    output logic [GHR_W-1:0] upd_ghr,
    output logic             upd_meta_en,
    output logic             upd_meta_sel,
    output logic             err_unmatched,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    logic [31:0]      q_pc     [DEPTH];
    logic             q_taken  [DEPTH];
    logic             q_global [DEPTH];
    logic             q_local  [DEPTH];
    logic [GHR_W-1:0] q_ghr    [DEPTH];

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;

    logic res_go;
    logic hit;
    logic matched;
    logic unmatched;
    logic mispred;
    logic enq;

    assign pred_ready = (count != CW'(DEPTH));

    always_comb begin
        res_go    = res_valid && !stall;
        hit       = (count != '0) && (res_pc == q_pc[head]);
        matched   = res_go && hit;
        unmatched = res_go && !hit;
        mispred   = matched && (res_taken != q_taken[head]);
        // A mispredict squashes everything younger, including this fetch.
        enq       = pred_valid && pred_ready && !stall && !mispred;
    end

    // Entry payload needs no reset; occupancy is tracked by count.
    always_ff @(posedge clk) begin
        if (enq) begin
            q_pc[tail]     <= pred_pc;
            q_taken[tail]  <= pred_taken;
            q_global[tail] <= pred_global;
            q_local[tail]  <= pred_local;
            q_ghr[tail]    <= ghr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            ghr           <= '0;
            flush         <= 1'b0;
            upd_valid     <= 1'b0;
            upd_pc        <= '0;
            upd_taken     <= 1'b0;
            upd_ghr       <= '0;
            upd_meta_en   <= 1'b0;
            upd_meta_sel  <= 1'b0;
            err_unmatched <= 1'b0;
            branch_cnt    <= '0;
            mispred_cnt   <= '0;
        end else begin
            upd_valid <= matched;
            flush     <= mispred;

            if (unmatched) begin
                err_unmatched <= 1'b1;
            end

            if (matched) begin
                upd_pc       <= q_pc[head];
                upd_taken    <= res_taken;
                upd_ghr      <= q_ghr[head];
                upd_meta_en  <= q_global[head] != q_local[head];
                upd_meta_sel <= q_local[head] == res_taken;
                if (branch_cnt != '1) begin
                    branch_cnt <= branch_cnt + CNT_W'(1);
                end
            end

            if (mispred) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
                // Rebuild history from the snapshot plus the true outcome.
                ghr   <= {q_ghr[head][GHR_W-2:0], res_taken};
                if (mispred_cnt != '1) begin
                    mispred_cnt <= mispred_cnt + CNT_W'(1);
                end
            end else begin
                if (matched) begin
                    head <= head + PW'(1);
                end
                if (enq) begin
                    tail <= tail + PW'(1);
                    ghr  <= {ghr[GHR_W-2:0], pred_taken};
                end
                count <= count + CW'(enq) - CW'(matched);
            end
        end
    end

endmodule

// File: tb/tb_br_pred_update_ctrl.sv
// Self-checking bench for br_pred_update_ctrl.
// Directed scenarios plus randomized traffic against a queue-based model.
module tb_br_pred_update_ctrl;

    localparam int DEPTH = 4;
    localparam int GHR_W = 8;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             stall;
    logic             pred_valid;
    logic [31:0]      pred_pc;
    logic             pred_taken;
    logic             pred_global;
    logic             pred_local;
    logic             pred_ready;
    logic             res_valid;
    logic [31:0]      res_pc;
    logic             res_taken;
    logic [GHR_W-1:0] ghr;
    logic             flush;
    logic             upd_valid;
    logic [31:0]      upd_pc;
    logic             upd_taken;
    logic [GHR_W-1:0] upd_ghr;
    logic             upd_meta_en;
    logic             upd_meta_sel;
    logic             err_unmatched;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] mispred_cnt;

    br_pred_update_ctrl #(
        .DEPTH(DEPTH),
        .GHR_W(GHR_W),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .stall(stall),
        .pred_valid(pred_valid),
        .pred_pc(pred_pc),
        .pred_taken(pred_taken),
        .pred_global(pred_global),
        .pred_local(pred_local),
        .pred_ready(pred_ready),
        .res_valid(res_valid),
        .res_pc(res_pc),
        .res_taken(res_taken),
        .ghr(ghr),
        .flush(flush),
        .upd_valid(upd_valid),
        .upd_pc(upd_pc),
        .upd_taken(upd_taken),
        .upd_ghr(upd_ghr),
        .upd_meta_en(upd_meta_en),
        .upd_meta_sel(upd_meta_sel),
        .err_unmatched(err_unmatched),
        .branch_cnt(branch_cnt),
        .mispred_cnt(mispred_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        bit          t;
        bit          g;
        bit          l;
        logic [7:0]  h;
    } ent_t;

    ent_t        mq[$];
    logic [7:0]  m_ghr;
    bit          m_err;
    int          m_bc;
    int          m_mc;
    bit          e_uv;
    bit          e_fl;
    bit          e_all;
    logic [31:0] e_pc;
    bit          e_t;
    logic [7:0]  e_ghr;
    bit          e_me;
    bit          e_ms;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    // Behavioural reference: a FIFO of branch records.
    task automatic model_step();
        bit   mis;
        bit   room;
        ent_t hd;
        ent_t ne;
        e_uv  = 0;
        e_fl  = 0;
        e_all = 0;
        if (rst) begin
            mq.delete();
            m_ghr = 0; m_err = 0; m_bc = 0; m_mc = 0;
            e_pc = 0; e_t = 0; e_ghr = 0; e_me = 0; e_ms = 0;
            e_all = 1;
            return;
        end
        mis  = 0;
        room = mq.size() < DEPTH;
        if (res_valid && !stall) begin
            if (mq.size() == 0 || mq[0].pc != res_pc) begin
                m_err = 1;
            end else begin
                hd    = mq.pop_front();
                e_uv  = 1;
                e_all = 1;
                e_pc  = hd.pc;
                e_t   = res_taken;
                e_ghr = hd.h;
                e_me  = hd.g != hd.l;
                e_ms  = hd.l == res_taken;
                if (m_bc < CMAX) m_bc++;
                if (hd.t != res_taken) begin
                    mis  = 1;
                    e_fl = 1;
                    mq.delete();
                    m_ghr = 8'((hd.h << 1) | 8'(res_taken));
                    if (m_mc < CMAX) m_mc++;
                end
            end
        end
        if (pred_valid && !stall && !mis && room) begin
            ne.pc = pred_pc; ne.t = pred_taken;
            ne.g = pred_global; ne.l = pred_local; ne.h = m_ghr;
            mq.push_back(ne);
            m_ghr = 8'((m_ghr << 1) | 8'(pred_taken));
        end
    endtask

    task automatic compare();
        chk("pred_ready", pred_ready, mq.size() < DEPTH);
        chk("ghr", ghr, m_ghr);
        chk("flush", flush, e_fl);
        chk("upd_valid", upd_valid, e_uv);
        chk("err_unmatched", err_unmatched, m_err);
        chk("branch_cnt", branch_cnt, m_bc);
        chk("mispred_cnt", mispred_cnt, m_mc);
        if (e_all) begin
            chk("upd_pc", upd_pc, e_pc);
            chk("upd_taken", upd_taken, e_t);
            chk("upd_ghr", upd_ghr, e_ghr);
            chk("upd_meta_en", upd_meta_en, e_me);
            chk("upd_meta_sel", upd_meta_sel, e_ms);
        end
    endtask

    task automatic cyc(input bit r, input bit st, input bit pv,
                       input logic [31:0] pc, input bit pt, input bit pg,
                       input bit pl, input bit rv, input logic [31:0] rpc,
                       input bit rt);
        rst = r; stall = st;
        pred_valid = pv; pred_pc = pc;
        pred_taken = pt; pred_global = pg; pred_local = pl;
        res_valid = rv; res_pc = rpc; res_taken = rt;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic reset1();
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic push(input logic [31:0] pc, input bit pt,
                        input bit pg, input bit pl);
        cyc(0, 0, 1, pc, pt, pg, pl, 0, 0, 0);
    endtask
    task automatic res(input logic [31:0] pc, input bit rt);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, pc, rt);
    endtask

    initial begin
        bit          st, r, pv, pt, pg, pl, rv, rt;
        logic [31:0] pc, rpc;

        // Reset state
        reset1();
        chk("rst_ready", pred_ready, 1);
        chk("rst_ghr", ghr, 0);
        chk("rst_upd_valid", upd_valid, 0);
        chk("rst_bc", branch_cnt, 0);

        // Basic enqueue and correct resolve
        push(32'h100, 1, 1, 1);
        push(32'h200, 1, 1, 1);
        push(32'h300, 1, 1, 1);
        chk("t1_ghr", ghr, 8'h07);
        chk("t1_ready", pred_ready, 1);
        res(32'h100, 1);
        chk("t1_uv", upd_valid, 1);
        chk("t1_upc", upd_pc, 32'h100);
        chk("t1_ughr", upd_ghr, 8'h00);
        chk("t1_flush", flush, 0);
        chk("t1_bc", branch_cnt, 1);
        idle();
        chk("t1_uv_pulse", upd_valid, 0);

        // Mispredict then stale resolve
        reset1();
        push(32'h100, 1, 1, 1);
        push(32'h200, 1, 1, 1);
        res(32'h100, 0);
        chk("t2_flush", flush, 1);
        chk("t2_ghr", ghr, 8'h00);
        chk("t2_mc", mispred_cnt, 1);
        idle();
        chk("t2_flush_pulse", flush, 0);
        res(32'h200, 1);
        chk("t2_err", err_unmatched, 1);
        chk("t2_bc", branch_cnt, 1);

        // Full queue
        reset1();
        push(32'h10, 1, 0, 0);
        push(32'h20, 0, 0, 0);
        push(32'h30, 1, 0, 0);
        push(32'h40, 0, 0, 0);
        chk("t3_full", pred_ready, 0);
        chk("t3_ghr", ghr, 8'h0A);
        push(32'h50, 1, 0, 0);
        chk("t3_ignored", ghr, 8'h0A);
        res(32'h10, 1);
        chk("t3_ready", pred_ready, 1);
        chk("t3_upd_ghr", upd_ghr, 8'h00);

        // Meta update
        reset1();
        push(32'h44, 1, 0, 1);
        res(32'h44, 1);
        chk("t4_me", upd_meta_en, 1);
        chk("t4_ms", upd_meta_sel, 1);
        push(32'h48, 1, 1, 1);
        res(32'h48, 1);
        chk("t4_me0", upd_meta_en, 0);

        // Simultaneous push/pop, correct and mispredicted
        reset1();
        push(32'h50, 1, 1, 1);
        push(32'h54, 1, 1, 1);
        cyc(0, 0, 1, 32'h58, 0, 0, 0, 1, 32'h50, 1);
        chk("t5_ghr", ghr, 8'h06);
        chk("t5_uv", upd_valid, 1);
        cyc(0, 0, 1, 32'h5C, 1, 1, 1, 1, 32'h54, 0);
        chk("t5_flush", flush, 1);
        chk("t5_ghr_fix", ghr, 8'h02);
        res(32'h58, 0);
        chk("t5_dropped", err_unmatched, 1);

        // Stall freeze, then mid-stream reset
        reset1();
        push(32'h60, 1, 1, 1);
        push(32'h64, 1, 1, 1);
        push(32'h68, 0, 1, 1);
        res(32'h60, 1);
        res(32'h999, 1);
        push(32'h6C, 1, 1, 1);
        chk("t6_ghr", ghr, 8'h0D);
        for (int i = 0; i < 3; i++)
            cyc(0, 1, 1, 32'h70, 1, 1, 1, 1, 32'h64, 0);
        chk("t6_stall_ghr", ghr, 8'h0D);
        chk("t6_stall_bc", branch_cnt, 1);
        chk("t6_stall_uv", upd_valid, 0);
        cyc(1, 0, 1, 32'h74, 1, 1, 1, 1, 32'h64, 0);
        chk("t6_rst_ghr", ghr, 0);
        chk("t6_rst_err", err_unmatched, 0);
        chk("t6_rst_bc", branch_cnt, 0);
        chk("t6_rst_ready", pred_ready, 1);

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            r   = ($urandom_range(0, 299) == 0);
            st  = ($urandom_range(0, 9) == 0);
            pv  = $urandom_range(0, 1);
            pc  = 32'($urandom_range(0, 255)) << 2;
            pt  = $urandom_range(0, 1);
            pg  = $urandom_range(0, 1);
            pl  = $urandom_range(0, 1);
            rv  = $urandom_range(0, 1);
            rpc = 32'($urandom_range(0, 255)) << 2;
            rt  = $urandom_range(0, 1);
            if (mq.size() > 0 && $urandom_range(0, 9) != 0)
                rpc = mq[0].pc;
            if (mq.size() > 0 && $urandom_range(0, 3) != 0)
                rt = mq[0].t;
            cyc(r, st, pv, pc, pt, pg, pl, rv, rpc, rt);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
